// File: rtl/bus_arb_3_pkg.sv
// rtl/bus_arb_3_pkg.sv - word width, datapath select codes and FSM state codes shared by bus_arb_3
`ifndef WORD
`define WORD 32
`endif

package bus_arb_3_pkg;

    localparam logic [1:0] SEL_R0 = 2'b00;
    localparam logic [1:0] SEL_R1 = 2'b01;
    localparam logic [1:0] SEL_R2 = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Pointer value after reset: "last granted was 2", so round-robin starts at 0.
    localparam logic [1:0] RR_PTR_RESET = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY,
        RESP = ST_RESP
    } state_t;

    function automatic logic [1:0] onehot_to_sel(input logic [2:0] oh);
        logic [1:0] s;
        case (oh)
            3'b010:  s = SEL_R1;
            3'b100:  s = SEL_R2;
            default: s = SEL_R0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/arb_pick_3.sv
// rtl/arb_pick_3.sv - combinational one-hot winner pick for three requesters (ARB_ROUND_ROBIN_EN selects round-robin)
module arb_pick_3 (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] win
);

`ifdef ARB_ROUND_ROBIN_EN
    // Search starts at the requester after the last-granted one and wraps.
    always_comb begin
        win = 3'b000;
        case (ptr)
            2'd0: begin
                if (req[1])      win = 3'b010;
                else if (req[2]) win = 3'b100;
                else if (req[0]) win = 3'b001;
            end
            2'd1: begin
                if (req[2])      win = 3'b100;
                else if (req[0]) win = 3'b001;
                else if (req[1]) win = 3'b010;
            end
            default: begin
                if (req[0])      win = 3'b001;
                else if (req[1]) win = 3'b010;
                else if (req[2]) win = 3'b100;
            end
        endcase
    end
`else
    // Fixed policy has no history, so the pointer input is intentionally ignored.
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Highest index always wins.
    always_comb begin
        win = 3'b000;
        if (req[2])      win = 3'b100;
        else if (req[1]) win = 3'b010;
        else if (req[0]) win = 3'b001;
    end
`endif

endmodule

// File: rtl/bus_arb_3.sv
// rtl/bus_arb_3.sv - three-requester arbiter onto one memory port (ARB_ROUND_ROBIN_EN selects round-robin)
`ifndef WORD
`define WORD 32
`endif

module bus_arb_3
    import bus_arb_3_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic [2:0]       req,
    input  logic [2:0]       we,
    input  logic [`WORD-1:0] addr0,
    input  logic [`WORD-1:0] addr1,
    input  logic [`WORD-1:0] addr2,
    input  logic [`WORD-1:0] wdata0,
    input  logic [`WORD-1:0] wdata1,
    input  logic [`WORD-1:0] wdata2,
    output logic             mem_req,
    output logic             mem_we,
    output logic [`WORD-1:0] mem_addr,
    output logic [`WORD-1:0] mem_wdata,
    input  logic             mem_ready,
    input  logic [`WORD-1:0] mem_rdata,
    output logic [1:0]       sel,
    output logic [2:0]       gnt,
    output logic [2:0]       done,
    output logic [`WORD-1:0] rdata
);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] win;
    logic [1:0] ptr;
    logic [2:0] gnt_nxt;
    logic [1:0] sel_nxt;
    logic       rdata_ld;
    logic       ptr_ld;

    arb_pick_3 u_pick (
        .req (req),
        .ptr (ptr),
        .win (win)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state plus the strobes that depend only on the current state.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        rdata_ld  = 1'b0;
        ptr_ld    = 1'b0;
        mem_req   = 1'b0;
        done      = 3'b000;
        case (state)
            IDLE: begin
                if (req != 3'b000) begin
                    gnt_nxt   = win;
                    sel_nxt   = onehot_to_sel(win);
                    state_nxt = BUSY;
                end else begin
                    gnt_nxt = 3'b000;
                    sel_nxt = SEL_R0;
                end
            end
            BUSY: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    rdata_ld  = 1'b1;
                    ptr_ld    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                done      = gnt;
                gnt_nxt   = 3'b000;
                sel_nxt   = SEL_R0;
                state_nxt = IDLE;
            end
            default: begin
                gnt_nxt   = 3'b000;
                sel_nxt   = SEL_R0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Grant/select are frozen from BUSY entry through RESP; rdata holds until the next completion.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gnt   <= 3'b000;
            sel   <= SEL_R0;
            rdata <= '0;
        end else begin
            gnt <= gnt_nxt;
            sel <= sel_nxt;
            if (rdata_ld) rdata <= mem_rdata;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remember the requester whose access just completed; sel encodes its index directly.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       ptr <= RR_PTR_RESET;
        else if (ptr_ld) ptr <= sel;
    end
`else
    logic unused_ptr_ld;
    assign unused_ptr_ld = ptr_ld;
    assign ptr           = RR_PTR_RESET;
`endif

    // Route the granted requester onto the memory port; write enable only counts while BUSY.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (sel)
            SEL_R0: begin
                mem_we    = we[0];
                mem_addr  = addr0;
                mem_wdata = wdata0;
            end
            SEL_R1: begin
                mem_we    = we[1];
                mem_addr  = addr1;
                mem_wdata = wdata1;
            end
            SEL_R2: begin
                mem_we    = we[2];
                mem_addr  = addr2;
                mem_wdata = wdata2;
            end
            default: begin
                mem_we    = 1'b0;
                mem_addr  = '0;
                mem_wdata = '0;
            end
        endcase
        if (state != BUSY) mem_we = 1'b0;
    end

endmodule

// File: tb/tb_bus_arb_3.sv
// tb/tb_bus_arb_3.sv - scoreboard bench for bus_arb_3 with a transaction-level reference model (ARB_ROUND_ROBIN_EN selects the policy)
`timescale 1ns/1ps

module tb_bus_arb_3;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [2:0]  we = 3'b000;
    logic [31:0] addr0 = '0, addr1 = '0, addr2 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0, wdata2 = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, rdata;
    logic [1:0]  sel;
    logic [2:0]  gnt, done;

    bus_arb_3 dut (
        .clk(clk), .rstn(rstn), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .sel(sel), .gnt(gnt), .done(done), .rdata(rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          k;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        int          arb;
        int          rdy;
        int          dn;
    } txn_t;

    txn_t        exp_q[$];
    txn_t        cur;
    int          order_log[$];
    int          checks = 0;
    int          errors = 0;

    logic [2:0]  pend = 3'b000;
    logic [2:0]  inj = 3'b000;
    logic [2:0]  p_we = 3'b000;
    logic [31:0] p_addr [3];
    logic [31:0] p_wdata [3];
    logic [31:0] p_rdata [3];
    int          p_wait [3];
    int          sticky [3];
    bit          active = 0;
    bit          in_reset = 1;
    bit          release_now = 0;
    int          rr_last = 2;
    int          rand_pct = 0;
    int          drop_pct = 0;
    logic [31:0] exp_rdata = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic int model_pick();
`ifdef ARB_ROUND_ROBIN_EN
        for (int i = 1; i <= 3; i++) begin
            if (pend[(rr_last + i) % 3]) return (rr_last + i) % 3;
        end
`else
        for (int k = 2; k >= 0; k--) begin
            if (pend[k]) return k;
        end
`endif
        return -1;
    endfunction

    task automatic new_fields(input int k);
        p_we[k]    = 1'($urandom_range(1));
        p_addr[k]  = $urandom;
        p_wdata[k] = $urandom;
        p_rdata[k] = $urandom;
        p_wait[k]  = ($urandom_range(9) == 0) ? int'($urandom_range(8)) : int'($urandom_range(2));
    endtask

    task automatic inject(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] rd, input int wt);
        p_we[k]    = w;
        p_addr[k]  = a;
        p_wdata[k] = d;
        p_rdata[k] = rd;
        p_wait[k]  = wt;
        inj[k]     = 1'b1;
    endtask

    task automatic flush_model();
        exp_q.delete();
        active    = 0;
        exp_rdata = '0;
        rr_last   = 2;
        mem_ready = 1'b0;
    endtask

    // One clock of requester, memory and reference-model activity.
    task automatic step();
        int k;
        @(posedge clk);
        #1;
        if (release_now) begin
            rstn        = 1'b1;
            release_now = 0;
            in_reset    = 0;
        end
        if (active && cyc == cur.dn + 1) begin
            active = 0;
            if (pend[cur.k]) begin
                if (sticky[cur.k] > 0) begin
                    sticky[cur.k]--;
                    new_fields(cur.k);
                end else begin
                    pend[cur.k] = 1'b0;
                end
            end
        end
        if (active && cyc > cur.arb && cyc <= cur.rdy && $urandom_range(99) < drop_pct)
            pend[cur.k] = 1'b0;
        for (int r = 0; r < 3; r++) begin
            if (!pend[r] && !(active && cur.k == r)) begin
                if (inj[r]) begin
                    pend[r] = 1'b1;
                    inj[r]  = 1'b0;
                end else if ($urandom_range(99) < rand_pct) begin
                    new_fields(r);
                    pend[r] = 1'b1;
                end
            end
        end
        req    = pend;
        we     = p_we;
        addr0  = p_addr[0];  addr1  = p_addr[1];  addr2  = p_addr[2];
        wdata0 = p_wdata[0]; wdata1 = p_wdata[1]; wdata2 = p_wdata[2];
        if (!active && !in_reset && pend != 3'b000) begin
            k       = model_pick();
            cur.k   = k;
            cur.w   = p_we[k];
            cur.a   = p_addr[k];
            cur.d   = p_wdata[k];
            cur.rd  = p_rdata[k];
            cur.arb = cyc;
            cur.rdy = cyc + 1 + p_wait[k];
            cur.dn  = cyc + 2 + p_wait[k];
            exp_q.push_back(cur);
            order_log.push_back(k);
            rr_last = k;
            active  = 1;
        end
        mem_ready = active && !in_reset && cyc == cur.rdy;
        mem_rdata = mem_ready ? cur.rd : $urandom;
    endtask

    task automatic wait_idle(input int budget);
        for (int n = 0; n < budget; n++) begin
            step();
            if (!active && pend == 3'b000 && inj == 3'b000 && exp_q.size() == 0) break;
        end
    endtask

    task automatic apply_reset();
        rstn     = 1'b0;
        in_reset = 1;
        flush_model();
        repeat (2) step();
        release_now = 1;
    endtask

    // Monitor: compare every cycle's outputs against the front of the expected-transaction queue.
    always @(negedge clk) begin
        if (in_reset) begin
            chk("rst_gnt", 32'(gnt), 0);
            chk("rst_sel", 32'(sel), 0);
            chk("rst_mem_req", 32'(mem_req), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_rdata", rdata, 0);
        end else if (exp_q.size() > 0 && cyc > exp_q[0].arb) begin
            chk("gnt", 32'(gnt), 32'd1 << exp_q[0].k);
            chk("sel", 32'(sel), 32'(exp_q[0].k));
            if (cyc <= exp_q[0].rdy) begin
                chk("busy_mem_req", 32'(mem_req), 1);
                chk("busy_done", 32'(done), 0);
                chk("mem_we", 32'(mem_we), 32'(exp_q[0].w));
                chk("mem_addr", mem_addr, exp_q[0].a);
                chk("mem_wdata", mem_wdata, exp_q[0].d);
            end else begin
                chk("resp_mem_req", 32'(mem_req), 0);
                chk("done", 32'(done), 32'd1 << exp_q[0].k);
                chk("rdata", rdata, exp_q[0].rd);
                exp_rdata = exp_q[0].rd;
                void'(exp_q.pop_front());
            end
        end else begin
            chk("idle_gnt", 32'(gnt), 0);
            chk("idle_sel", 32'(sel), 0);
            chk("idle_mem_req", 32'(mem_req), 0);
            chk("idle_done", 32'(done), 0);
            chk("held_rdata", rdata, exp_rdata);
        end
    end

    initial begin
        int exp_order[5];
        for (int i = 0; i < 3; i++) begin
            p_addr[i] = '0; p_wdata[i] = '0; p_rdata[i] = '0; p_wait[i] = 0; sticky[i] = 0;
        end
        apply_reset();

        inject(0, 1'b0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0);
        wait_idle(50);

        inject(1, 1'b1, 32'h0000_2000, 32'h1234_5678, 32'h0BAD_F00D, 0);
        wait_idle(50);

        inject(2, 1'b0, 32'h0000_3000, 32'h0, 32'h5555_AAAA, 5);
        wait_idle(50);

        inject(0, 1'b0, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 6);
        for (int n = 0; n < 20 && !(active && cyc == cur.arb + 3); n++) step();
        #2;
        rstn     = 1'b0;
        in_reset = 1;
        flush_model();
        #1;
        chk("async_mem_req", 32'(mem_req), 0);
        chk("async_done", 32'(done), 0);
        chk("async_gnt", 32'(gnt), 0);
        chk("async_sel", 32'(sel), 0);
        chk("async_rdata", rdata, 0);
        repeat (2) step();
        release_now = 1;
        wait_idle(50);

        step();
        apply_reset();
        order_log.delete();
        sticky[2] = 2;
        inject(0, 1'b0, 32'h0000_0100, 32'h0, 32'h1111_1111, 0);
        inject(1, 1'b1, 32'h0000_0200, 32'h2222_2222, 32'h3333_3333, 1);
        inject(2, 1'b0, 32'h0000_0300, 32'h0, 32'h4444_4444, 0);
        wait_idle(100);
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 2, 2, 2};
`else
        exp_order = '{2, 2, 2, 1, 0};
`endif
        chk("order_len", 32'(order_log.size()), 5);
        for (int i = 0; i < 5 && i < order_log.size(); i++)
            chk("grant_order", 32'(order_log[i]), 32'(exp_order[i]));

        rand_pct = 35;
        drop_pct = 10;
        repeat (3000) step();
        rand_pct = 0;
        drop_pct = 0;
        wait_idle(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
